oam_dma_ctrl: RTL and testbench



---
 rtl/oam_dma_pkg.sv | 15 +
 rtl/oam_dma_ctrl_if.sv | 30 +++
 rtl/oam_dma_ctrl.sv | 91 +++++++++
 tb/tb_oam_dma_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/oam_dma_pkg.sv
// Shared types and default constants for the OAM DMA controller.
package oam_dma_pkg;

  localparam int unsigned IDX_BITS  = 8;
  localparam int unsigned PAGE_BITS = 8;
  localparam int unsigned DMA_LEN   = 160;
  localparam logic [15:0] OAM_BASE  = 16'hFE00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dma_state_e;

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// Trigger, source-read, destination-write and status signals of the OAM DMA.
interface oam_dma_ctrl_if
  import oam_dma_pkg::*;
#(
  parameter int unsigned p_ADDR_BITS = 16,
  parameter int unsigned p_DATA_BITS = 8
);

  logic                   trig;
  logic [PAGE_BITS-1:0]   trig_page;
  logic [p_ADDR_BITS-1:0] src_addr;
  logic                   src_ren;
  logic [p_DATA_BITS-1:0] src_q;
  logic [p_ADDR_BITS-1:0] dst_addr;
  logic                   dst_wen;
  logic [p_DATA_BITS-1:0] dst_data;
  logic                   busy;
  logic                   done;

  modport master (
    input  trig, trig_page, src_q,
    output src_addr, src_ren, dst_addr, dst_wen, dst_data, busy, done
  );

  modport slave (
    output trig, trig_page, src_q,
    input  src_addr, src_ren, dst_addr, dst_wen, dst_data, busy, done
  );

endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA: copies p_LEN bytes from page {trig_page,00} to p_DST_BASE,
// one byte per cycle, with the write trailing the read by one cycle.
module oam_dma_ctrl
  import oam_dma_pkg::*;
#(
  parameter int unsigned            p_ADDR_BITS = 16,
  parameter int unsigned            p_DATA_BITS = 8,
  parameter int unsigned            p_LEN       = DMA_LEN,
  parameter logic [p_ADDR_BITS-1:0] p_DST_BASE  = p_ADDR_BITS'(OAM_BASE)
) (
  input  logic           clk,
  input  logic           reset,
  oam_dma_ctrl_if.master bus
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(p_LEN - 1);

  dma_state_e           r_state;
  dma_state_e           w_state_nxt;
  logic [PAGE_BITS-1:0] r_page;
  logic [PAGE_BITS-1:0] w_page_nxt;
  logic [IDX_BITS-1:0]  r_rd_idx;
  logic [IDX_BITS-1:0]  w_rd_idx_nxt;
  logic [IDX_BITS-1:0]  r_wr_idx;
  logic                 r_rd_valid;
  logic                 w_rd_valid_nxt;

  logic [p_ADDR_BITS-1:0] w_src_addr;
  logic [p_ADDR_BITS-1:0] w_dst_addr;
  logic [p_DATA_BITS-1:0] w_dst_data;

  // State and counter registers; wr_idx is rd_idx delayed by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_page     <= '0;
      r_rd_idx   <= '0;
      r_wr_idx   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_page     <= w_page_nxt;
      r_rd_idx   <= w_rd_idx_nxt;
      r_wr_idx   <= r_rd_idx;
      r_rd_valid <= w_rd_valid_nxt;
    end
  end

  // Next-state logic; a trigger in any state (re)starts the transfer.
  always_comb begin
    w_state_nxt    = r_state;
    w_page_nxt     = r_page;
    w_rd_idx_nxt   = r_rd_idx;
    w_rd_valid_nxt = 1'b0;

    case (r_state)
      IDLE: ;
      RUN: begin
        w_rd_idx_nxt   = r_rd_idx + 8'd1;
        w_rd_valid_nxt = 1'b1;
        if (r_rd_idx == LAST_IDX) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Restart drops the in-flight read so its write never happens.
    if (bus.trig) begin
      w_state_nxt    = RUN;
      w_page_nxt     = bus.trig_page;
      w_rd_idx_nxt   = '0;
      w_rd_valid_nxt = 1'b0;
    end
  end

  assign w_src_addr = p_ADDR_BITS'({r_page, r_rd_idx});
  assign w_dst_addr = p_DST_BASE + p_ADDR_BITS'(r_wr_idx);
  assign w_dst_data = bus.src_q;

  // Outputs decode registered state only; addresses read as zero when idle.
  assign bus.src_ren  = (r_state == RUN);
  assign bus.src_addr = (r_state == RUN) ? w_src_addr : '0;
  assign bus.dst_wen  = r_rd_valid;
  assign bus.dst_addr = r_rd_valid ? w_dst_addr : '0;
  assign bus.dst_data = w_dst_data;
  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = (r_state == DRAIN);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench: two DMA instances (160- and 256-byte) against array RAM models.
module tb_oam_dma_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  oam_dma_ctrl_if #(.p_ADDR_BITS(16), .p_DATA_BITS(8)) bus_a ();
  oam_dma_ctrl_if #(.p_ADDR_BITS(16), .p_DATA_BITS(8)) bus_b ();

  oam_dma_ctrl #(
    .p_ADDR_BITS(16), .p_DATA_BITS(8), .p_LEN(160), .p_DST_BASE(16'hFE00)
  ) u_dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );

  oam_dma_ctrl #(
    .p_ADDR_BITS(16), .p_DATA_BITS(8), .p_LEN(256), .p_DST_BASE(16'hFE00)
  ) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  logic [7:0] src_mem [0:65535];
  logic [7:0] dst_a   [0:65535];
  logic [7:0] dst_b   [0:65535];

  // Synchronous RAM models: read data one cycle after ren, write on wen.
  always @(posedge clk) begin
    if (bus_a.src_ren) bus_a.src_q <= src_mem[bus_a.src_addr];
    if (bus_a.dst_wen) dst_a[bus_a.dst_addr] <= bus_a.dst_data;
    if (bus_b.src_ren) bus_b.src_q <= src_mem[bus_b.src_addr];
    if (bus_b.dst_wen) dst_b[bus_b.dst_addr] <= bus_b.dst_data;
  end

  int n_checks = 0;
  int n_err    = 0;
  int n_busy;
  int n_done;
  int done_cyc;

  function automatic logic [7:0] pat(input logic [7:0] page, input int i);
    case (page)
      8'hC1:   pat = 8'(i) ^ 8'h5A;
      8'hD0:   pat = 8'(i * 7 + 3);
      8'hE0:   pat = 8'(255 - i);
      default: pat = 8'(i) ^ 8'hC3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_a(input string tag);
    chk(tag, 32'({bus_a.src_ren, bus_a.dst_wen, bus_a.busy, bus_a.done}), 32'h0);
    chk(tag, 32'({bus_a.src_addr, bus_a.dst_addr}), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      dst_a[i] = 8'h00;
      dst_b[i] = 8'h00;
      src_mem[i] = 8'h00;
    end
    for (int i = 0; i < 256; i++) begin
      src_mem[16'hC100 + i] = pat(8'hC1, i);
      src_mem[16'hD000 + i] = pat(8'hD0, i);
      src_mem[16'hE000 + i] = pat(8'hE0, i);
      src_mem[16'hFF00 + i] = pat(8'hFF, i);
    end

    // Reset, then idle for 10 cycles with everything at zero.
    reset = 1'b1;
    bus_a.trig = 1'b0; bus_a.trig_page = 8'h00;
    bus_b.trig = 1'b0; bus_b.trig_page = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_idle_a("idle_a");
      chk("idle_b", 32'({bus_b.src_ren, bus_b.dst_wen, bus_b.busy, bus_b.done}), 32'h0);
    end

    // Full transfer from page C1.
    bus_a.trig = 1'b1; bus_a.trig_page = 8'hC1;
    n_busy = 0; n_done = 0; done_cyc = 0;
    for (int c = 1; c <= 170; c++) begin
      tick();
      if (c == 1) bus_a.trig = 1'b0;
      if (bus_a.busy) n_busy++;
      if (bus_a.done) begin n_done++; done_cyc = c; end
      if (c == 1) begin
        chk("t2_c1_src_addr", 32'(bus_a.src_addr), 32'hC100);
        chk("t2_c1_src_ren",  32'(bus_a.src_ren), 32'h1);
        chk("t2_c1_dst_wen",  32'(bus_a.dst_wen), 32'h0);
      end
      if (c == 2) begin
        chk("t2_c2_dst_wen",  32'(bus_a.dst_wen), 32'h1);
        chk("t2_c2_dst_addr", 32'(bus_a.dst_addr), 32'hFE00);
        chk("t2_c2_dst_data", 32'(bus_a.dst_data), 32'h5A);
      end
      if (c == 161) begin
        chk("t2_last_dst_wen",  32'(bus_a.dst_wen), 32'h1);
        chk("t2_last_dst_addr", 32'(bus_a.dst_addr), 32'hFE9F);
        chk("t2_last_done",     32'(bus_a.done), 32'h1);
        chk("t2_last_src_ren",  32'(bus_a.src_ren), 32'h0);
      end
    end
    chk("t2_busy_cycles", 32'(n_busy), 32'd161);
    chk("t2_done_count",  32'(n_done), 32'd1);
    chk("t2_done_cycle",  32'(done_cyc), 32'd161);
    for (int i = 0; i < 160; i++)
      chk("t2_dst_data", 32'(dst_a[16'hFE00 + i]), 32'(pat(8'hC1, i)));
    chk("t2_no_overrun", 32'(dst_a[16'hFEA0]), 32'h0);
    chk_idle_a("t2_idle_after");

    // Restart: page C1, then page D0 triggered at cycle 50.
    bus_a.trig = 1'b1; bus_a.trig_page = 8'hC1;
    n_busy = 0; n_done = 0; done_cyc = 0;
    for (int c = 1; c <= 230; c++) begin
      tick();
      if (c == 1 || c == 51) bus_a.trig = 1'b0;
      if (bus_a.busy) n_busy++;
      if (bus_a.done) begin n_done++; done_cyc = c; end
      if (c == 50) chk("t3_c50_dst_wen", 32'(bus_a.dst_wen), 32'h1);
      if (c == 51) begin
        chk("t3_c51_dst_wen",  32'(bus_a.dst_wen), 32'h0);
        chk("t3_c51_src_addr", 32'(bus_a.src_addr), 32'hD000);
      end
      if (c == 52) chk("t3_c52_dst_addr", 32'(bus_a.dst_addr), 32'hFE00);
      if (c == 50) begin bus_a.trig = 1'b1; bus_a.trig_page = 8'hD0; end
    end
    chk("t3_busy_cycles", 32'(n_busy), 32'd211);
    chk("t3_done_count",  32'(n_done), 32'd1);
    chk("t3_done_cycle",  32'(done_cyc), 32'd211);
    for (int i = 0; i < 160; i++)
      chk("t3_dst_data", 32'(dst_a[16'hFE00 + i]), 32'(pat(8'hD0, i)));

    // Reset at cycle 80 of a transfer, then a clean transfer from page E0.
    bus_a.trig = 1'b1; bus_a.trig_page = 8'hC1;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (c == 1) bus_a.trig = 1'b0;
    end
    chk("t4_busy_before_reset", 32'(bus_a.busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle_a("t4_after_reset");
    repeat (2) tick();
    bus_a.trig = 1'b1; bus_a.trig_page = 8'hE0;
    n_busy = 0; n_done = 0; done_cyc = 0;
    for (int c = 1; c <= 170; c++) begin
      tick();
      if (c == 1) bus_a.trig = 1'b0;
      if (bus_a.busy) n_busy++;
      if (bus_a.done) begin n_done++; done_cyc = c; end
    end
    chk("t4_busy_cycles", 32'(n_busy), 32'd161);
    chk("t4_done_count",  32'(n_done), 32'd1);
    chk("t4_done_cycle",  32'(done_cyc), 32'd161);
    for (int i = 0; i < 160; i++)
      chk("t4_dst_data", 32'(dst_a[16'hFE00 + i]), 32'(pat(8'hE0, i)));

    // 256-byte transfer from page FF: no carry into the page.
    bus_b.trig = 1'b1; bus_b.trig_page = 8'hFF;
    n_busy = 0; n_done = 0; done_cyc = 0;
    for (int c = 1; c <= 265; c++) begin
      tick();
      if (c == 1) bus_b.trig = 1'b0;
      if (bus_b.busy) n_busy++;
      if (bus_b.done) begin n_done++; done_cyc = c; end
      if (c <= 256) begin
        chk("t5_src_addr", 32'(bus_b.src_addr), 32'(32'hFF00 + c - 1));
        chk("t5_src_ren",  32'(bus_b.src_ren), 32'h1);
      end
      if (c >= 2 && c <= 257) begin
        chk("t5_dst_addr", 32'(bus_b.dst_addr), 32'(32'hFE00 + c - 2));
        chk("t5_dst_wen",  32'(bus_b.dst_wen), 32'h1);
      end
    end
    chk("t5_busy_cycles", 32'(n_busy), 32'd257);
    chk("t5_done_count",  32'(n_done), 32'd1);
    chk("t5_done_cycle",  32'(done_cyc), 32'd257);
    for (int i = 0; i < 256; i++)
      chk("t5_dst_data", 32'(dst_b[16'hFE00 + i]), 32'(pat(8'hFF, i)));
    chk("t5_no_page_carry", 32'(dst_b[16'hFF00]), 32'h0);

    // Trigger and reset in the same cycle: reset wins, nothing starts.
    reset = 1'b1;
    bus_a.trig = 1'b1; bus_a.trig_page = 8'hC1;
    tick();
    reset = 1'b0;
    bus_a.trig = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk_idle_a("t6_trig_with_reset");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
